dual_wb_stage: RTL and testbench

//  Writeback pipeline stage for the dual-issue datapath; sits directly upstream of the 8x32 register file.

---
 rtl/dual_wb_pkg.sv | 10 +
 rtl/dual_wb_stage_slot_reg.sv | 20 ++
 rtl/dual_wb_stage.sv | 77 +++++++
 tb/tb_dual_wb_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/dual_wb_pkg.sv
// dual_wb_pkg: shared widths and the per-slot result record for the writeback stage
package dual_wb_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 3;
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_slot_t;
endpackage

// File: rtl/dual_wb_stage_slot_reg.sv
// wb_slot_reg: one writeback slot holding register; holds on stall, invalidates on flush
module wb_slot_reg
  import dual_wb_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     stall,
  input  logic     flush,
  input  wb_slot_t in_slot,
  output wb_slot_t slot_q
);
  wb_slot_t slot_d;
  always_comb begin
    slot_d   = (stall || flush) ? slot_q : in_slot;
    slot_d.v = flush ? 1'b0 : slot_d.v;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) slot_q <= '0;
    else slot_q <= slot_d;
endmodule

// File: rtl/dual_wb_stage.sv
// dual_wb_stage: dual-issue writeback stage with collision resolution, write-once and retire counter.
// Define DUAL_WB_BYPASS_EN to add a two-port operand bypass lookup on the stage registers.
module dual_wb_stage
  import dual_wb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid1,
  input  logic [REG_AW-1:0] in_dest1,
  input  logic [DATA_W-1:0] in_data1,
  input  logic              in_valid2,
  input  logic [REG_AW-1:0] in_dest2,
  input  logic [DATA_W-1:0] in_data2,
  output logic              regWrite1,
  output logic [REG_AW-1:0] destReg1,
  output logic [DATA_W-1:0] writeData1,
  output logic              regWrite2,
  output logic [REG_AW-1:0] destReg2,
  output logic [DATA_W-1:0] writeData2,
  output logic              collision,
  output logic [CNT_W-1:0]  retired_count
`ifdef DUAL_WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0] byp_addr_a,
  input  logic [REG_AW-1:0] byp_addr_b,
  output logic              byp_hit_a,
  output logic              byp_hit_b,
  output logic [DATA_W-1:0] byp_data_a,
  output logic [DATA_W-1:0] byp_data_b
`endif
);
  wb_slot_t in1, in2, s1_q, s2_q;
  logic capture, done_d, done_q, sup1_d, sup1_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  assign in1 = '{v: in_valid1, dest: in_dest1, data: in_data1};
  assign in2 = '{v: in_valid2, dest: in_dest2, data: in_data2};
  assign capture = ~stall & ~flush;
  wb_slot_reg u_slot1 (.clk, .reset, .stall, .flush, .in_slot(in1), .slot_q(s1_q));
  wb_slot_reg u_slot2 (.clk, .reset, .stall, .flush, .in_slot(in2), .slot_q(s2_q));
  // Any non-capture edge retires the presented pair, so it can never write twice.
  always_comb begin
    done_d = ~capture;
    sup1_d = capture ? (in_valid1 & in_valid2 & (in_dest1 == in_dest2)) : sup1_q;
    cnt_d  = capture ? cnt_q + CNT_W'(in_valid1) + CNT_W'(in_valid2) : cnt_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      done_q <= 1'b0;
      sup1_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= done_d;
      sup1_q <= sup1_d;
      cnt_q  <= cnt_d;
    end
  assign regWrite1     = s1_q.v & ~sup1_q & ~done_q;
  assign regWrite2     = s2_q.v & ~done_q;
  assign destReg1      = s1_q.dest;
  assign writeData1    = s1_q.data;
  assign destReg2      = s2_q.dest;
  assign writeData2    = s2_q.data;
  assign collision     = sup1_q & ~done_q;
  assign retired_count = cnt_q;
`ifdef DUAL_WB_BYPASS_EN
  // Slot 2 is younger, so it shadows slot 1 on a matching address.
  function automatic logic [DATA_W:0] lookup(input logic [REG_AW-1:0] a);
    return (regWrite2 && destReg2 == a) ? {1'b1, writeData2} :
           (regWrite1 && destReg1 == a) ? {1'b1, writeData1} : '0;
  endfunction
  assign {byp_hit_a, byp_data_a} = lookup(byp_addr_a);
  assign {byp_hit_b, byp_data_b} = lookup(byp_addr_b);
`endif
endmodule

// File: tb/tb_dual_wb_stage.sv
// tb_dual_wb_stage: scoreboard bench for dual_wb_stage with a 4-bit retire counter to exercise wrap
module tb_dual_wb_stage;
  typedef logic [76:0] obs_t;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic in_valid1 = 1'b0, in_valid2 = 1'b0;
  logic [2:0] in_dest1 = '0, in_dest2 = '0;
  logic [31:0] in_data1 = '0, in_data2 = '0;
  logic regWrite1, regWrite2, collision;
  logic [2:0] destReg1, destReg2;
  logic [31:0] writeData1, writeData2;
  logic [3:0] retired_count;
`ifdef DUAL_WB_BYPASS_EN
  logic [2:0] byp_addr_a = '0, byp_addr_b = '0;
  logic byp_hit_a, byp_hit_b;
  logic [31:0] byp_data_a, byp_data_b;
`endif
  int checks = 0, errors = 0;
  obs_t exp_q[$];
  int id_q[$];

  dual_wb_stage #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid1(in_valid1), .in_dest1(in_dest1), .in_data1(in_data1),
    .in_valid2(in_valid2), .in_dest2(in_dest2), .in_data2(in_data2),
    .regWrite1(regWrite1), .destReg1(destReg1), .writeData1(writeData1),
    .regWrite2(regWrite2), .destReg2(destReg2), .writeData2(writeData2),
    .collision(collision), .retired_count(retired_count)
`ifdef DUAL_WB_BYPASS_EN
    , .byp_addr_a(byp_addr_a), .byp_addr_b(byp_addr_b),
    .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b),
    .byp_data_a(byp_data_a), .byp_data_b(byp_data_b)
`endif
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {regWrite1, regWrite2, destReg1, writeData1, destReg2, writeData2, collision, retired_count};
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk($sformatf("step %0d", id_q.pop_front()), observe(), exp_q.pop_front());
  end

  task automatic cyc(input int id, input int st, fl, v1, d1, x1, v2, d2, x2,
                     input int e1, e2, ed1, ew1, ed2, ew2, ec, en);
    @(negedge clk);
    stall = 1'(st); flush = 1'(fl);
    in_valid1 = 1'(v1); in_dest1 = 3'(d1); in_data1 = 32'(x1);
    in_valid2 = 1'(v2); in_dest2 = 3'(d2); in_data2 = 32'(x2);
    exp_q.push_back({1'(e1), 1'(e2), 3'(ed1), 32'(ew1), 3'(ed2), 32'(ew2), 1'(ec), 4'(en)});
    id_q.push_back(id);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset state", observe(), '0);
    reset = 1'b0;
    cyc(1, 0,0, 1,3,'h11, 1,5,'h22,  1,1, 3,'h11, 5,'h22, 0,2);
    cyc(2, 0,0, 1,4,'hA,  1,4,'hB,   0,1, 4,'hA,  4,'hB,  1,4);
    cyc(3, 0,0, 0,0,0,    0,0,0,     0,0, 0,0,    0,0,    0,4);
    cyc(4, 0,0, 1,1,'h33, 1,2,'h44,  1,1, 1,'h33, 2,'h44, 0,6);
    for (int i = 0; i < 3; i++)
      cyc(5 + i, 1,0, 1,6,'h99, 1,7,'h88, 0,0, 1,'h33, 2,'h44, 0,6);
    cyc(8,  0,0, 0,0,0,    0,0,0,     0,0, 0,0,    0,0,    0,6);
    cyc(9,  0,0, 1,6,'h1,  1,6,'h2,   0,1, 6,'h1,  6,'h2,  1,8);
    cyc(10, 1,0, 1,5,'h9,  1,5,'h9,   0,0, 6,'h1,  6,'h2,  0,8);
    cyc(11, 1,1, 1,3,'h77, 1,4,'h66,  0,0, 6,'h1,  6,'h2,  0,8);
    cyc(12, 0,0, 1,7,'h70, 1,0,'h80,  1,1, 7,'h70, 0,'h80, 0,10);
    cyc(13, 0,1, 1,1,'h5,  1,2,'h6,   0,0, 7,'h70, 0,'h80, 0,10);
    cyc(14, 0,0, 1,2,'h12, 1,3,'h13,  1,1, 2,'h12, 3,'h13, 0,12);
    cyc(15, 0,0, 0,5,'hFF, 1,5,'h21,  0,1, 5,'hFF, 5,'h21, 0,13);
    cyc(16, 0,0, 1,0,'h31, 0,0,'h32,  1,0, 0,'h31, 0,'h32, 0,14);
    cyc(17, 0,0, 1,1,'h41, 0,0,0,     1,0, 1,'h41, 0,0,    0,15);
    cyc(18, 0,0, 1,3,'h51, 1,4,'h52,  1,1, 3,'h51, 4,'h52, 0,1);
`ifdef DUAL_WB_BYPASS_EN
    @(posedge clk);
    #2;
    byp_addr_a = 3'd4; byp_addr_b = 3'd3;
    #1;
    chk("bypass hits", obs_t'({byp_hit_a, byp_data_a, byp_hit_b, byp_data_b}), obs_t'({1'b1, 32'h52, 1'b1, 32'h51}));
    byp_addr_b = 3'd6;
    #1;
    chk("bypass miss", obs_t'({byp_hit_b, byp_data_b}), '0);
`endif
    cyc(19, 0,0, 1,1,'h61, 1,2,'h62,  1,1, 1,'h61, 2,'h62, 0,3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid-cycle reset", observe(), '0);
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc(20, 0,0, 1,3,'h71, 1,4,'h72,  1,1, 3,'h71, 4,'h72, 0,2);
    cyc(21, 0,0, 0,0,0,    0,0,0,     0,0, 0,0,    0,0,    0,2);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", obs_t'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
